serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing diff = a − b over WIDTH bits, one bit per clock, LSB first, through a single full-subtractor cell and a borrow flop. Operands enter and results leave over valid/ready handshakes. It is the area-minimal subtraction counterpart to the team's parallel adder, for datapaths that can trade latency for gates.

## Interface
- WIDTH, default 8: operand/result width in bits; must be ≥ 1 (elaboration error otherwise).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend (unsigned or two's complement).
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- diff  output  WIDTH  (a − b) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned.
- overflow  output  1  signed overflow; present only with SERIAL_SUBTRACTOR_OVERFLOW_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid=1 at a rising edge, capture a and b into shift registers, clear the borrow flop, clear the bit counter, and go to RUN.
- RUN: in_ready=0, out_valid=0. Each edge processes bit i = a_sh[0], b_sh[0], and borrow:
  - d = a^b^borrow
  - borrow_next = (~a & b) | (~(a^b) & borrow)
  - d shifts into the diff register MSB; the operand registers shift right; the counter increments.
  - After bit WIDTH−1 is processed, latch borrow_next into borrow_out and go to DONE.
- DONE: out_valid=1. diff, borrow_out and overflow are held stable. When out_ready=1 at an edge, go to IDLE.
- a and b are sampled only on the accepting edge. Later changes are ignored.
- diff and borrow_out are valid only while out_valid=1. They are not cleared on leaving DONE.
- Counter width is $clog2(WIDTH+1). The terminal count is WIDTH−1. WIDTH=1 gives exactly one RUN cycle.
- Reset (rst_n low, any state, including mid-RUN): the operation is aborted with no output. State goes to IDLE; out_valid=0, diff=0, borrow_out=0, overflow=0, counter=0, borrow=0.
- in_ready decodes to state==IDLE, so it reads 1 during reset. No transfer occurs while rst_n is low.

## Timing
- Accepting edge E0. Edges E1…E_WIDTH process bits 0…WIDTH−1. out_valid rises after E_WIDTH, i.e. WIDTH cycles after acceptance.
- A consuming edge in DONE returns to IDLE. The next acceptance comes on a later edge, so back-to-back throughput is one result per WIDTH+2 cycles.
- in_ready and out_valid are never high in the same cycle.
- All outputs are registered except in_ready, which is a state decode.

## Configuration
- SERIAL_SUBTRACTOR_OVERFLOW_EN defined:
  - The overflow port exists and is a register, set on the final RUN edge to (a[MSB] ≠ b[MSB]) && (d[MSB] ≠ a[MSB]).
  - The MSB of each captured operand is kept in a flop for this purpose.
  - overflow resets to 0 and is held in DONE like diff.
- Not defined: the port and its flops are absent; everything else is identical.

## Structure
- Package serial_subtractor_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - a function computing the counter width from WIDTH.
- Sub-module full_subtractor: combinational, inputs a, b, borrow_in; outputs diff, borrow_out. It is instantiated once.
- The FSM, counter, shift registers and borrow flop live in the top module.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, out_ready=1:
  - diff=0x37, borrow_out=0.
  - out_valid rises exactly 8 cycles after acceptance and lasts 1 cycle.
- a=0x00, b=0x01: diff=0xFF, borrow_out=1, overflow=0.
- a=0x80, b=0x01 with the macro defined: diff=0x7F, borrow_out=0, overflow=1.
- Backpressure: out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1, diff/borrow_out stay stable, in_ready stays 0.
  - Consumed on the first edge with out_ready=1.
- rst_n pulsed low after 3 RUN edges of a=0xF0, b=0x0F:
  - Immediately out_valid=0, diff=0, in_ready=1.
  - The next op a=0x10, b=0x10 yields diff=0x00, borrow_out=0.
- Two ops a=b=0xFF with in_valid and out_ready tied high: results 0x00/0 each, acceptances spaced exactly WIDTH+2 = 10 cycles apart.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional feature macro: SERIAL_SUBTRACTOR_OVERFLOW_EN (signed overflow output).
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to represent 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// Optional feature macro: SERIAL_SUBTRACTOR_OVERFLOW_EN adds the overflow signal.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             overflow;
`endif

    // Producer of operands / consumer of results.
    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        input  overflow,
`endif
        input  borrow_out
    );

    // The subtractor itself.
    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        output overflow,
`endif
        output borrow_out
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - borrow_in.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);
    // Borrow is generated when a=0,b=1, or propagated when a==b.
    always_comb begin
        diff       = a ^ b ^ borrow_in;
        borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
    end
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit
// per clock through a single full-subtractor cell and a borrow flop.
// Optional feature macro: SERIAL_SUBTRACTOR_OVERFLOW_EN (signed overflow flag).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("serial_subtractor: WIDTH must be >= 1");
        end
    endgenerate

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic             borrow_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_out_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] diff_next;
    logic             fs_diff;
    logic             fs_borrow;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic             overflow_reg;
`endif

    full_subtractor u_full_subtractor (
        .a          (a_sh_reg[0]),
        .b          (b_sh_reg[0]),
        .borrow_in  (borrow_reg),
        .diff       (fs_diff),
        .borrow_out (fs_borrow)
    );

    // New result bit enters at the MSB so that after WIDTH shifts bit 0 lands at LSB.
    always_comb begin
        diff_next            = diff_reg >> 1;
        diff_next[WIDTH-1]   = fs_diff;
    end

    // FSM, operand shifters, borrow flop, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            a_sh_reg       <= '0;
            b_sh_reg       <= '0;
            borrow_reg     <= 1'b0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            a_msb_reg      <= 1'b0;
            b_msb_reg      <= 1'b0;
            overflow_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh_reg   <= bus.a;
                        b_sh_reg   <= bus.b;
                        borrow_reg <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                        a_msb_reg  <= bus.a[WIDTH-1];
                        b_msb_reg  <= bus.b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    borrow_reg <= fs_borrow;
                    diff_reg   <= diff_next;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CNT) begin
                        borrow_out_reg <= fs_borrow;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                        // fs_diff is the result MSB on this final edge.
                        overflow_reg   <= (a_msb_reg != b_msb_reg) && (fs_diff != a_msb_reg);
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_reg == IDLE);
    assign bus.out_valid  = out_valid_reg;
    assign bus.diff       = diff_reg;
    assign bus.borrow_out = borrow_out_reg;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    assign bus.overflow   = overflow_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with an expected-result queue.
// Overflow checks are compiled only with SERIAL_SUBTRACTOR_OVERFLOW_EN.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: widen to WIDTH+1 bits, the extra bit is the borrow.
    task automatic push_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        exp_t e;
        r        = {1'b0, a} - {1'b0, b};
        e.diff   = r[WIDTH-1:0];
        e.borrow = r[WIDTH];
        e.ovf    = (a[WIDTH-1] ^ b[WIDTH-1]) & (r[WIDTH-1] ^ a[WIDTH-1]);
        sb.push_back(e);
    endtask

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~a;   // must be ignored after acceptance
        bus.b        = ~b;
    endtask

    // Waits for the result, checks latency/values, optionally holds off out_ready.
    task automatic collect(input string tag, input int hold);
        int   n;
        exp_t e;
        logic [WIDTH-1:0] held_diff;
        logic             held_borrow;
        n = 0;
        @(negedge clk);
        check({tag, "_in_ready_run"}, 32'(bus.in_ready), 32'd0);
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(n), 32'(WIDTH));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_diff"}, 32'(bus.diff), 32'(e.diff));
            check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(e.borrow));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            check({tag, "_ovf"}, 32'(bus.overflow), 32'(e.ovf));
`endif
            $display("[TB] %s diff=0x%0h borrow=%0b latency=%0d", tag, bus.diff, bus.borrow_out, n);
        end
        held_diff   = bus.diff;
        held_borrow = bus.borrow_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_diff"}, 32'(bus.diff), 32'(held_diff));
            check({tag, "_hold_borrow"}, 32'(bus.borrow_out), 32'(held_borrow));
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_consumed"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int acc[2];
        int nacc;
        int nres;
        exp_t e;
        logic [WIDTH-1:0] ra, rb;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_borrow", 32'(bus.borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic: 0x5A - 0x23
        push_model(8'h5A, 8'h23);
        check("model_5a_23", 32'(sb[0].diff), 32'h37);
        accept(8'h5A, 8'h23);
        collect("op_5a_23", 0);

        // Wrap-around with borrow
        push_model(8'h00, 8'h01);
        accept(8'h00, 8'h01);
        collect("op_00_01", 0);

        // Signed overflow case
        push_model(8'h80, 8'h01);
        accept(8'h80, 8'h01);
        collect("op_80_01", 0);

        // Backpressure for 5 cycles
        push_model(8'h5A, 8'h23);
        bus.out_ready = 1'b0;
        accept(8'h5A, 8'h23);
        collect("op_bp", 5);

        // Reset after 3 RUN edges
        accept(8'hF0, 8'h0F);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_diff", 32'(bus.diff), 32'd0);
        check("abort_borrow", 32'(bus.borrow_out), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        $display("[TB] abort mid-run out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_model(8'h10, 8'h10);
        accept(8'h10, 8'h10);
        collect("op_10_10", 0);

        // A few random operand pairs
        for (int k = 0; k < 3; k++) begin
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            push_model(ra, rb);
            accept(ra, rb);
            collect("op_rand", 0);
        end

        // Back-to-back: in_valid and out_ready held high
        bus.a         = 8'hFF;
        bus.b         = 8'hFF;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        nacc = 0;
        nres = 0;
        acc[0] = 0;
        acc[1] = 0;
        for (int k = 0; k < 40 && nres < 2; k++) begin
            if (bus.out_valid) begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("b2b_diff", 32'(bus.diff), 32'(e.diff));
                    check("b2b_borrow", 32'(bus.borrow_out), 32'(e.borrow));
                    $display("[TB] b2b result diff=0x%0h borrow=%0b", bus.diff, bus.borrow_out);
                end
                nres++;
            end
            if (bus.in_ready && nacc < 2) begin
                acc[nacc] = cyc;
                push_model(8'hFF, 8'hFF);
                nacc++;
            end
            @(posedge clk);
            #1;
            if (nacc == 2) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_results", 32'(nres), 32'd2);
        check("b2b_spacing", 32'(acc[1] - acc[0]), 32'(WIDTH + 2));
        $display("[TB] b2b acceptances at cycles %0d and %0d", acc[0], acc[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
